// File: rtl/noise61_pkg.sv
// Shared definitions for the 61-bit noise LFSR: length, taps, reference seed,
// checker state encoding and the single-step advance function.
package noise61_pkg;

   localparam int LFSR_LEN = 61;
   localparam int TAP_A    = 60;
   localparam int TAP_B    = 59;
   localparam int TAP_C    = 45;
   localparam int TAP_D    = 44;

   localparam logic [LFSR_LEN-1:0] REF_SEED = 61'h0C2887F2CB7DB6FE;

   typedef enum logic [2:0] {
      ACQ   = 3'd0,
      LOAD  = 3'd1,
      TRACK = 3'd2,
      STEP  = 3'd3,
      CMP   = 3'd4
   } state_t;

   // One-bit advance: left shift, feedback bit enters at bit 0.
   function automatic logic [LFSR_LEN-1:0] lfsr61_step(input logic [LFSR_LEN-1:0] s);
      return {s[LFSR_LEN-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction

endpackage

// File: rtl/lfsr61_core.sv
// Serial 61-bit LFSR stepper with a parallel load port. Load wins over step.
module lfsr61_core
   import noise61_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [LFSR_LEN-1:0] load_val,
   input  logic                step,
   output logic [LFSR_LEN-1:0] sr
);

   // LFSR state: cleared on reset, loaded from acquisition, or advanced one bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sr <= '0;
      else if (load)
         sr <= load_val;
      else if (step)
         sr <= lfsr61_step(sr);
   end

endmodule

// File: rtl/noise61_checker.sv
// PRBS checker for the 61-bit noise LFSR stream. Acquires the generator state
// from ACQ_WORDS raw words, then predicts each following word by stepping a
// local LFSR DSZ times and counts word mismatches.
// Optional macro NOISE61_CHK_BITERR_EN adds a saturating per-bit error count.
module noise61_checker
   import noise61_pkg::*;
#(
   parameter int DSZ         = 18,
   parameter int LOSS_THRESH = 3,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [DSZ-1:0]   in,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic             overrun,
   output logic             busy
`ifdef NOISE61_CHK_BITERR_EN
   ,
   output logic [23:0]      bit_err_count
`endif
);

   localparam int ACQ_WORDS = (LFSR_LEN + DSZ - 1) / DSZ;
   localparam int ACQ_CW    = $clog2(ACQ_WORDS + 1);
   localparam int STEP_CW   = $clog2(DSZ + 1);
   localparam int MISS_W    = $clog2(LOSS_THRESH + 1);
   localparam logic [LFSR_LEN-1:0] WORD_MASK = LFSR_LEN'((62'd1 << DSZ) - 62'd1);

   state_t               state, state_nxt;
   logic [LFSR_LEN-1:0]  hist;
   logic [LFSR_LEN-1:0]  sr;
   logic [DSZ-1:0]       wbuf;
   logic [ACQ_CW-1:0]    acq_cnt;
   logic [STEP_CW-1:0]   step_cnt;
   logic [MISS_W-1:0]    miss_cnt;
   logic [MISS_W-1:0]    miss_nxt;
   logic [LFSR_LEN-1:0]  diff;
   logic                 mismatch;
   logic                 lose;
   logic                 sr_load;
   logic                 sr_step;
   logic                 ovr_set;

   // Prediction vs captured word; upper LFSR bits are masked off.
   assign diff     = sr ^ LFSR_LEN'(wbuf);
   assign mismatch = |(diff & WORD_MASK);
   assign miss_nxt = miss_cnt + 1'b1;
   assign lose     = mismatch && (miss_nxt >= MISS_W'(LOSS_THRESH));

   lfsr61_core u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (sr_load),
      .load_val (hist),
      .step     (sr_step),
      .sr       (sr)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ACQ;
      else
         state <= state_nxt;
   end

   // Next-state decode and LFSR / status controls.
   always_comb begin
      state_nxt = state;
      sr_load   = 1'b0;
      sr_step   = 1'b0;
      busy      = 1'b0;
      ovr_set   = 1'b0;
      case (state)
         ACQ: begin
            if (ena && acq_cnt == ACQ_CW'(ACQ_WORDS - 1))
               state_nxt = LOAD;
         end
         LOAD: begin
            sr_load   = 1'b1;
            ovr_set   = ena;
            state_nxt = (hist == '0) ? ACQ : TRACK;
         end
         TRACK: begin
            if (ena)
               state_nxt = STEP;
         end
         STEP: begin
            busy    = 1'b1;
            sr_step = 1'b1;
            ovr_set = ena;
            if (step_cnt == '0)
               state_nxt = CMP;
         end
         CMP: begin
            busy      = 1'b1;
            ovr_set   = ena;
            state_nxt = lose ? ACQ : TRACK;
         end
         default: state_nxt = ACQ;
      endcase
   end

   // Datapath: acquisition history, word buffer, counters and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist      <= '0;
         wbuf      <= '0;
         acq_cnt   <= '0;
         step_cnt  <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
         overrun   <= 1'b0;
      end else begin
         err <= 1'b0;
         if (ovr_set)
            overrun <= 1'b1;
         case (state)
            ACQ: begin
               if (ena) begin
                  hist    <= LFSR_LEN'({hist, in});
                  acq_cnt <= acq_cnt + 1'b1;
               end
            end
            LOAD: begin
               acq_cnt <= '0;
               locked  <= (hist != '0);
            end
            TRACK: begin
               if (ena) begin
                  wbuf     <= in;
                  step_cnt <= STEP_CW'(DSZ - 1);
               end
            end
            STEP: step_cnt <= step_cnt - 1'b1;
            CMP: begin
               if (mismatch) begin
                  err <= 1'b1;
                  if (err_count != {CNT_W{1'b1}})
                     err_count <= err_count + 1'b1;
                  if (lose) begin
                     miss_cnt <= '0;
                     acq_cnt  <= '0;
                     locked   <= 1'b0;
                  end else begin
                     miss_cnt <= miss_nxt;
                  end
               end else begin
                  miss_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef NOISE61_CHK_BITERR_EN
   logic [6:0]  pop;
   logic [24:0] bit_sum;

   // Number of differing bits in the compared word.
   always_comb begin
      pop = '0;
      for (int i = 0; i < DSZ; i++)
         pop = pop + 7'(diff[i]);
   end

   assign bit_sum = {1'b0, bit_err_count} + 25'(pop);

   // Saturating bit error accumulator, updated in CMP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bit_err_count <= '0;
      else if (state == CMP)
         bit_err_count <= bit_sum[24] ? 24'hFFFFFF : bit_sum[23:0];
   end
`endif

endmodule

// File: tb/tb_noise61_checker.sv
// Directed bench for noise61_checker (DSZ=18). Generator model is a bit-serial
// 61-bit LFSR seeded with the reference seed, stepping 18 times per word.
module tb_noise61_checker;
   import noise61_pkg::*;

   localparam int DSZ = 18;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ena = 1'b0;
   logic [DSZ-1:0]  in_w = '0;
   logic            locked, err, overrun, busy;
   logic [15:0]     err_count;
`ifdef NOISE61_CHK_BITERR_EN
   logic [23:0]     bit_err_count;
`endif

   logic [60:0]     gen_sr;
   int              checks = 0;
   int              passed = 0;
   int              err_pulses = 0;
   int              lock_seen = 0;

   always #5 clk = ~clk;

   noise61_checker #(.DSZ(DSZ), .LOSS_THRESH(3), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in        (in_w),
      .locked    (locked),
      .err       (err),
      .err_count (err_count),
      .overrun   (overrun),
      .busy      (busy)
`ifdef NOISE61_CHK_BITERR_EN
      ,
      .bit_err_count (bit_err_count)
`endif
   );

   // Generator model: 18 serial steps, then emit the low 18 bits.
   task automatic next_word(output logic [DSZ-1:0] w);
      for (int i = 0; i < DSZ; i++)
         gen_sr = {gen_sr[59:0], gen_sr[60] ^ gen_sr[59] ^ gen_sr[45] ^ gen_sr[44]};
      w = gen_sr[DSZ-1:0];
   endtask

   // One-cycle ena strobe; returns 1 time unit after the capturing edge.
   task automatic pulse(input logic [DSZ-1:0] w);
      ena  = 1'b1;
      in_w = w;
      @(posedge clk); #1;
      ena  = 1'b0;
   endtask

   // Idle n cycles while tallying err pulses and any locked assertion.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (err) err_pulses++;
         if (locked) lock_seen = 1;
      end
   endtask

   task automatic do_reset();
      ena = 1'b0;
      in_w = '0;
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      gen_sr = REF_SEED;
      err_pulses = 0;
      lock_seen = 0;
   endtask

   task automatic do_lock();
      logic [DSZ-1:0] w;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         next_word(w);
         pulse(w);
         idle(23);
      end
   endtask

   task automatic test_reset();
      ena = 1'b0; rst_n = 1'b0;
      #12;
      checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
      checks++; if (err_count !== 16'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else passed++;
      checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_clean_lock();
      logic [DSZ-1:0] w;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         next_word(w);
         pulse(w);
         if (i < 3) idle(23);
      end
      checks++; if (locked !== 1'b0) $display("FAIL lock_early got %b want 0", locked); else passed++;
      idle(1);
      checks++; if (locked !== 1'b1) $display("FAIL lock_rise got %b want 1", locked); else passed++;
      idle(22);
      err_pulses = 0;
      for (int i = 0; i < 200; i++) begin
         next_word(w);
         pulse(w);
         idle(23);
      end
      checks++; if (err_pulses != 0) $display("FAIL clean_err_pulses got %0d want 0", err_pulses); else passed++;
      checks++; if (err_count !== 16'd0) $display("FAIL clean_err_count got %0d want 0", err_count); else passed++;
      checks++; if (locked !== 1'b1) $display("FAIL clean_locked got %b want 1", locked); else passed++;
   endtask

   task automatic test_single_bit_error();
      logic [DSZ-1:0] w;
      int err_edge;
      logic busy_at_exit;
      for (int i = 0; i < 9; i++) begin
         next_word(w);
         pulse(w);
         idle(23);
      end
      next_word(w);
      pulse(w ^ 18'h00001);
      checks++; if (busy !== 1'b1) $display("FAIL sbe_busy_step got %b want 1", busy); else passed++;
      err_edge = -1;
      busy_at_exit = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(posedge clk); #1;
         if (err && err_edge < 0) err_edge = k;
         if (k == 19) busy_at_exit = busy;
      end
      checks++; if (err_edge != 19) $display("FAIL sbe_latency got %0d want 19", err_edge); else passed++;
      checks++; if (busy_at_exit !== 1'b0) $display("FAIL sbe_busy_exit got %b want 0", busy_at_exit); else passed++;
      @(posedge clk); #1;
      checks++; if (err !== 1'b0) $display("FAIL sbe_err_width got %b want 0", err); else passed++;
      checks++; if (err_count !== 16'd1) $display("FAIL sbe_err_count got %0d want 1", err_count); else passed++;
      checks++; if (locked !== 1'b1) $display("FAIL sbe_locked got %b want 1", locked); else passed++;
`ifdef NOISE61_CHK_BITERR_EN
      checks++; if (bit_err_count !== 24'd1) $display("FAIL sbe_bit_err_count got %0d want 1", bit_err_count); else passed++;
`endif
      idle(3);
      err_pulses = 0;
      for (int i = 0; i < 3; i++) begin
         next_word(w);
         pulse(w);
         idle(23);
      end
      checks++; if (err_count !== 16'd1) $display("FAIL sbe_after_count got %0d want 1", err_count); else passed++;
   endtask

   task automatic test_loss_reacquire();
      logic [DSZ-1:0] w;
      do_lock();
      for (int i = 0; i < 3; i++) begin
         next_word(w);
         pulse(w ^ 18'h2A5A5);
         idle(19);
         if (i < 2) begin
            checks++; if (locked !== 1'b1) $display("FAIL loss_hold%0d got %b want 1", i, locked); else passed++;
         end
         idle(4);
      end
      checks++; if (locked !== 1'b0) $display("FAIL loss_drop got %b want 0", locked); else passed++;
      checks++; if (err_count !== 16'd3) $display("FAIL loss_err_count got %0d want 3", err_count); else passed++;
      for (int i = 0; i < 4; i++) begin
         next_word(w);
         pulse(w);
         if (i < 3) idle(23);
      end
      checks++; if (locked !== 1'b0) $display("FAIL reacq_early got %b want 0", locked); else passed++;
      idle(1);
      checks++; if (locked !== 1'b1) $display("FAIL reacq_rise got %b want 1", locked); else passed++;
      idle(22);
      err_pulses = 0;
      next_word(w);
      pulse(w);
      idle(23);
      checks++; if (err_count !== 16'd3) $display("FAIL reacq_err_count got %0d want 3", err_count); else passed++;
   endtask

   task automatic test_zero_lockup();
      logic [DSZ-1:0] w;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         pulse('0);
         idle(2);
      end
      checks++; if (lock_seen != 0) $display("FAIL zero_locked got %0d want 0", lock_seen); else passed++;
      checks++; if (overrun !== 1'b0) $display("FAIL zero_overrun got %b want 0", overrun); else passed++;
      for (int i = 0; i < 4; i++) begin
         next_word(w);
         pulse(w);
         idle(2);
      end
      checks++; if (locked !== 1'b1) $display("FAIL zero_relock got %b want 1", locked); else passed++;
   endtask

   task automatic test_continuous_ena();
      logic [DSZ-1:0] w;
      do_reset();
      ena = 1'b1;
      for (int i = 0; i < 4; i++) begin
         next_word(w);
         in_w = w;
         @(posedge clk); #1;
      end
      in_w = 18'h3C3C3;
      checks++; if (locked !== 1'b0) $display("FAIL cont_early got %b want 0", locked); else passed++;
      @(posedge clk); #1;
      ena = 1'b0;
      checks++; if (locked !== 1'b1) $display("FAIL cont_locked got %b want 1", locked); else passed++;
      checks++; if (overrun !== 1'b1) $display("FAIL cont_load_overrun got %b want 1", overrun); else passed++;
      idle(4);
      err_pulses = 0;
      next_word(w);
      pulse(w);
      idle(23);
      checks++; if (err_pulses != 0) $display("FAIL cont_err_pulses got %0d want 0", err_pulses); else passed++;
   endtask

   task automatic test_overrun();
      logic [DSZ-1:0] w;
      do_lock();
      checks++; if (overrun !== 1'b0) $display("FAIL ovr_pre got %b want 0", overrun); else passed++;
      err_pulses = 0;
      next_word(w);
      pulse(w);
      idle(9);
      pulse(18'h12345);
      checks++; if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun); else passed++;
      idle(13);
      checks++; if (err_count !== 16'd0) $display("FAIL ovr_err_count got %0d want 0", err_count); else passed++;
      next_word(w);
      pulse(w);
      idle(23);
      checks++; if (err_pulses != 0) $display("FAIL ovr_err_pulses got %0d want 0", err_pulses); else passed++;
      checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else passed++;
   endtask

   task automatic test_reset_mid_step();
      logic [DSZ-1:0] w;
      do_lock();
      next_word(w);
      pulse(w ^ 18'h00100);
      idle(23);
      next_word(w);
      pulse(w);
      idle(2);
      pulse(18'h0F0F0);
      checks++; if (busy !== 1'b1 || overrun !== 1'b1 || err_count !== 16'd1)
         $display("FAIL rst_pre got busy=%b ovr=%b cnt=%0d want 1 1 1", busy, overrun, err_count);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (locked !== 1'b0) $display("FAIL rst_async_locked got %b want 0", locked); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL rst_async_err got %b want 0", err); else passed++;
      checks++; if (err_count !== 16'd0) $display("FAIL rst_async_err_count got %0d want 0", err_count); else passed++;
      checks++; if (overrun !== 1'b0) $display("FAIL rst_async_overrun got %b want 0", overrun); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy got %b want 0", busy); else passed++;
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_single_bit_error();
      test_loss_reacquire();
      test_zero_lockup();
      test_continuous_ena();
      test_overrun();
      test_reset_mid_step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/noise61_checker.md
Name: noise61_checker

Overview:
- PRBS checker and receiver for the 61-bit LFSR noise stream (taps 60,59,45,44; left shift, new bit into bit 0; DSZ fresh bits per word).
- Self-synchronises from the raw LFSR word tapped before the IIR low-pass, then predicts each following word and counts mismatches.
- Used on the synth test board and in simulation to qualify noise sources and their enable pacing.

Parameters:
- DSZ, 18: word width and LFSR steps per word. Legal range 1..61.
- LOSS_THRESH, 3: consecutive word mismatches that drop lock. Legal range ≥1.
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  word strobe; in is sampled on the clk edge where ena=1
- in  in  DSZ  raw LFSR word (generator sr[DSZ-1:0])
- locked  out  1  checker synchronised and tracking
- err  out  1  one-cycle pulse on a word mismatch
- err_count  out  CNT_W  saturating error count
- overrun  out  1  sticky: ena arrived while busy
- busy  out  1  checker stepping or comparing

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=ACQ; acq_cnt=0; miss_cnt=0; history and local LFSR cleared.
- ACQ_WORDS = ceil(61/DSZ); this is 4 for DSZ=18.
- ACQ state:
  - On ena: hist <= {hist, in}, a left shift by DSZ; acq_cnt increments.
  - On the edge that captures word ACQ_WORDS: next state LOAD.
- LOAD state (1 cycle):
  - Local sr <= hist[60:0].
  - If hist[60:0]==0 (LFSR lockup state), return to ACQ with acq_cnt=0.
  - Otherwise go to TRACK and set locked=1. locked rises exactly 1 cycle after the 4th ena edge.
  - ena during LOAD sets overrun and is ignored.
- TRACK state:
  - On ena: capture in into wbuf; step_cnt=DSZ-1; go to STEP; busy=1.
- STEP state:
  - Each clk: sr <= {sr[59:0], sr[60]^sr[59]^sr[45]^sr[44]}; step_cnt decrements.
  - After the step with step_cnt==0, go to CMP.
- CMP state (1 cycle): compare sr[DSZ-1:0] with wbuf.
  - Mismatch: err=1 for this cycle only; err_count+1, saturating at all-ones; miss_cnt+1.
  - Mismatch with miss_cnt reaching LOSS_THRESH: locked=0, go to ACQ, clear acq_cnt and miss_cnt.
  - Match: miss_cnt=0.
  - Otherwise return to TRACK. busy drops the same cycle CMP exits.
- Latency: err asserted on the (DSZ+1)th edge after the ena edge. Minimum ena spacing is DSZ+2 cycles.
- ena while busy (STEP/CMP): word dropped, overrun<=1 (sticky until reset), tracking unaffected.
- Local LFSR never resynchronises from data while locked. A dropped word therefore shows up as mismatches on the following words.
- err_count and overrun survive loss of lock; only rst_n clears them.
- ena held high continuously: each cycle in ACQ captures a word.

Optional Feature:
- Macro: NOISE61_CHK_BITERR_EN.
- Defined:
  - Adds output bit_err_count[23:0], saturating.
  - In CMP it adds popcount(sr[DSZ-1:0]^wbuf), computed combinationally in that cycle.
- Undefined: port absent; only word errors are counted.

Decomposition:
- Shared package noise61_pkg:
  - LFSR_LEN=61; tap constants 60,59,45,44.
  - Reference seed 61'h0C2887F2CB7DB6FE.
  - State enum {ACQ, LOAD, TRACK, STEP, CMP}.
  - Function lfsr61_step (one-bit advance).
- Sub-module lfsr61_core: serial stepper with load port. Reusable by a future generator rewrite.

Test Plan:
- Reset: assert rst_n=0 mid-STEP → locked, err, err_count, overrun, busy all 0 immediately, without waiting for a clock edge.
- Clean lock: model generator from seed 61'h0C2887F2CB7DB6FE, ena every 24 clocks → locked=1 one cycle after 4th ena; 200 further words give err_count=0 and err never pulses.
- Single bit error: flip in[0] on word 10 after lock → one err pulse 19 edges after that ena; err_count=1; locked stays 1. With BITERR_EN, bit_err_count=1.
- Loss/reacquire: corrupt 3 consecutive words → locked=0 after the 3rd CMP; err_count=3; lock regained 1 cycle after 4 further clean enas.
- Zero lockup: drive in=0 for 20 enas → locked never asserts; FSM cycles ACQ→LOAD→ACQ.
- Overrun: in TRACK, ena twice 10 clocks apart → overrun=1; second word ignored; err_count unchanged on the following CMP.
